bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 107 ++++++++++
 tb/tb_bus_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with registered grants, latched owner
// address/direction, per-grant timeout and a one-cycle turnaround between grants.
module bus_arbiter #(
  parameter logic [3:0] TIMEOUT_CYC = 4'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m1_req,
  input  logic [13:0] m1_addr,
  input  logic        m1_rw,
  input  logic        m2_req,
  input  logic [13:0] m2_addr,
  input  logic        m2_rw,
  input  logic        bus_done,
  output logic        m1_grant,
  output logic        m2_grant,
  output logic [13:0] bus_addr,
  output logic        bus_rw,
  output logic        bus_valid,
  output logic        bus_timeout
);

  typedef enum logic [1:0] {IDLE, GNT_M1, GNT_M2, TURN} state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic        r_last_m2, w_last_m2_next;
  logic [13:0] r_addr, w_addr_next;
  logic        r_rw, w_rw_next;
  logic        r_tmo, w_tmo_next;
  logic        r_m1_grant, r_m2_grant, r_valid;
  logic        w_own_req;
  logic        w_timeout_hit;

  assign w_own_req = (r_state == GNT_M2) ? m2_req : m1_req;
  // r_cnt counts grant cycles already completed, so this marks the
  // TIMEOUT_CYC-th cycle of the grant.
  assign w_timeout_hit = (r_cnt == (TIMEOUT_CYC - 4'd1));

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_last_m2_next = r_last_m2;
    w_addr_next    = r_addr;
    w_rw_next      = r_rw;
    w_tmo_next     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (m1_req && (!m2_req || r_last_m2)) begin
          w_state_next   = GNT_M1;
          w_cnt_next     = 4'd0;
          w_last_m2_next = 1'b0;
          w_addr_next    = m1_addr;
          w_rw_next      = m1_rw;
        end else if (m2_req) begin
          w_state_next   = GNT_M2;
          w_cnt_next     = 4'd0;
          w_last_m2_next = 1'b1;
          w_addr_next    = m2_addr;
          w_rw_next      = m2_rw;
        end
      end
      GNT_M1, GNT_M2: begin
        w_cnt_next = r_cnt + 4'd1;
        if (bus_done || !w_own_req || w_timeout_hit) begin
          w_state_next = TURN;
          // A completion or abort on the timeout cycle is not a timeout.
          w_tmo_next   = !bus_done && w_own_req && w_timeout_hit;
        end
      end
      TURN:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_last_m2  <= 1'b1;
      r_addr     <= 14'h0000;
      r_rw       <= 1'b0;
      r_tmo      <= 1'b0;
      r_m1_grant <= 1'b0;
      r_m2_grant <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_last_m2  <= w_last_m2_next;
      r_addr     <= w_addr_next;
      r_rw       <= w_rw_next;
      r_tmo      <= w_tmo_next;
      r_m1_grant <= (w_state_next == GNT_M1);
      r_m2_grant <= (w_state_next == GNT_M2);
      r_valid    <= (w_state_next == GNT_M1) || (w_state_next == GNT_M2);
    end
  end

  assign m1_grant    = r_m1_grant;
  assign m2_grant    = r_m2_grant;
  assign bus_valid   = r_valid;
  assign bus_addr    = r_addr;
  assign bus_rw      = r_rw;
  assign bus_timeout = r_tmo;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, timeout corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m1_req, m1_rw, m2_req, m2_rw, bus_done;
  logic [13:0] m1_addr, m2_addr;
  logic        m1_grant, m2_grant, bus_valid, bus_timeout, bus_rw;
  logic [13:0] bus_addr;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter dut (
    .clk(clk), .rst(rst),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_rw(m1_rw),
    .m2_req(m2_req), .m2_addr(m2_addr), .m2_rw(m2_rw),
    .bus_done(bus_done),
    .m1_grant(m1_grant), .m2_grant(m2_grant),
    .bus_addr(bus_addr), .bus_rw(bus_rw),
    .bus_valid(bus_valid), .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, whether we are in the turnaround gap,
  // how many cycles the current owner has held it, and who won last.
  int          m_owner;
  bit          m_gap;
  int          m_held;
  int          m_last;
  logic [13:0] m_addr;
  logic        m_rw, m_tmo;

  task automatic model_edge();
    bit owner_req;
    int winner;
    m_tmo = 1'b0;
    if (rst) begin
      m_owner = 0; m_gap = 0; m_held = 0; m_last = 2;
      m_addr = 14'h0000; m_rw = 1'b0;
    end else if (m_gap) begin
      m_gap = 0;
    end else if (m_owner != 0) begin
      m_held++;
      owner_req = (m_owner == 1) ? m1_req : m2_req;
      if (bus_done || !owner_req || m_held == 15) begin
        m_tmo   = !bus_done && owner_req && (m_held == 15);
        m_owner = 0;
        m_gap   = 1;
      end
    end else begin
      winner = 0;
      if (m1_req && m2_req) winner = (m_last == 1) ? 2 : 1;
      else if (m1_req)      winner = 1;
      else if (m2_req)      winner = 2;
      if (winner != 0) begin
        m_owner = winner; m_last = winner; m_held = 0;
        m_addr  = (winner == 1) ? m1_addr : m2_addr;
        m_rw    = (winner == 1) ? m1_rw : m2_rw;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [18:0] dut_vec();
    return {m1_grant, m2_grant, bus_valid, bus_timeout, bus_rw, bus_addr};
  endfunction

  // One clock: model follows the inputs sampled at the edge, outputs checked 1ns later.
  task automatic step(input string name);
    logic [18:0] exp;
    @(posedge clk);
    model_edge();
    #1;
    exp = {m_owner == 1, m_owner == 2, m_owner != 0, m_tmo, m_rw, m_addr};
    check(name, {13'd0, dut_vec()}, {13'd0, exp});
    $display("cyc rst=%0b req=%0b%0b done=%0b -> g1=%0b g2=%0b v=%0b to=%0b addr=%h rw=%0b",
             rst, m1_req, m2_req, bus_done, m1_grant, m2_grant, bus_valid, bus_timeout, bus_addr, bus_rw);
  endtask

  typedef struct {
    logic        rst, r1, rw1, r2, rw2, done;
    logic [13:0] a1, a2;
    logic        g1, g2, v, to, rw;
    logic [13:0] addr;
  } vec_t;

  vec_t tbl[16];
  int   g_cnt, t_cnt;

  initial begin
    rst = 1'b1; m1_req = 0; m1_rw = 0; m2_req = 0; m2_rw = 0; bus_done = 0;
    m1_addr = '0; m2_addr = '0;

    //           rst r1 rw1 r2 rw2 dn  a1        a2        g1 g2 v to rw addr
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 14'h0000, 14'h0000, 0, 0, 0, 0, 0, 14'h0000};
    tbl[1]  = '{0, 1, 1, 0, 0, 0, 14'h1234, 14'h0000, 1, 0, 1, 0, 1, 14'h1234};
    tbl[2]  = '{0, 1, 1, 0, 0, 1, 14'h1234, 14'h0000, 0, 0, 0, 0, 1, 14'h1234};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 14'h0000, 14'h0000, 0, 0, 0, 0, 1, 14'h1234};
    tbl[4]  = '{0, 1, 0, 1, 1, 0, 14'h0111, 14'h2ABC, 0, 1, 1, 0, 1, 14'h2ABC};
    tbl[5]  = '{0, 1, 0, 1, 1, 0, 14'h0111, 14'h0001, 0, 1, 1, 0, 1, 14'h2ABC};
    tbl[6]  = '{0, 1, 0, 1, 1, 1, 14'h0111, 14'h0001, 0, 0, 0, 0, 1, 14'h2ABC};
    tbl[7]  = '{0, 1, 0, 1, 1, 0, 14'h0111, 14'h0001, 0, 0, 0, 0, 1, 14'h2ABC};
    tbl[8]  = '{0, 1, 0, 1, 1, 0, 14'h0111, 14'h0001, 1, 0, 1, 0, 0, 14'h0111};
    tbl[9]  = '{0, 1, 0, 1, 1, 1, 14'h0111, 14'h0001, 0, 0, 0, 0, 0, 14'h0111};
    tbl[10] = '{0, 1, 0, 1, 1, 0, 14'h0111, 14'h0001, 0, 0, 0, 0, 0, 14'h0111};
    tbl[11] = '{0, 1, 0, 1, 1, 0, 14'h0111, 14'h0001, 0, 1, 1, 0, 1, 14'h0001};
    tbl[12] = '{1, 1, 0, 1, 1, 0, 14'h0111, 14'h0001, 0, 0, 0, 0, 0, 14'h0000};
    tbl[13] = '{0, 1, 0, 1, 1, 0, 14'h0111, 14'h0001, 1, 0, 1, 0, 0, 14'h0111};
    tbl[14] = '{0, 0, 0, 1, 1, 0, 14'h0111, 14'h0001, 0, 0, 0, 0, 0, 14'h0111};
    tbl[15] = '{1, 0, 0, 0, 0, 0, 14'h0000, 14'h0000, 0, 0, 0, 0, 0, 14'h0000};

    for (int i = 0; i < 16; i++) begin
      #1;
      rst = tbl[i].rst; m1_req = tbl[i].r1; m1_rw = tbl[i].rw1; m1_addr = tbl[i].a1;
      m2_req = tbl[i].r2; m2_rw = tbl[i].rw2; m2_addr = tbl[i].a2; bus_done = tbl[i].done;
      step("model_vec");
      check("vec_outputs", {13'd0, dut_vec()},
            {13'd0, tbl[i].g1, tbl[i].g2, tbl[i].v, tbl[i].to, tbl[i].rw, tbl[i].addr});
    end

    // Timeout: grant held 15 cycles without completion, then a single pulse.
    rst = 0; m2_req = 0; m1_req = 1; m1_addr = 14'h3FFF; m1_rw = 0; bus_done = 0;
    g_cnt = 0; t_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step("timeout_seq");
      if (m1_grant) g_cnt++;
      if (bus_timeout) begin
        t_cnt++;
        m1_req = 0;
      end
    end
    check("timeout_grant_cycles", g_cnt, 15);
    check("timeout_pulses", t_cnt, 1);

    // Completion on the timeout cycle: normal end, no pulse.
    m1_req = 1; m1_addr = 14'h0AAA; m1_rw = 1;
    step("done_tmo_entry");
    check("done_tmo_granted", {31'd0, m1_grant}, 32'd1);
    for (int i = 0; i < 14; i++) step("done_tmo_hold");
    bus_done = 1;
    step("done_tmo_edge");
    check("done_tmo_no_pulse", {30'd0, bus_timeout, m1_grant}, 32'd0);
    bus_done = 0; m1_req = 0;
    step("done_tmo_after");
    check("done_tmo_quiet", {31'd0, bus_timeout}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 5) == 0) m1_req = ~m1_req;
      if ($urandom_range(0, 5) == 0) m2_req = ~m2_req;
      m1_addr  = 14'($urandom); m1_rw = 1'($urandom);
      m2_addr  = 14'($urandom); m2_rw = 1'($urandom);
      bus_done = ($urandom_range(0, 9) == 0);
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
